spectrum_vram_writer: RTL and testbench

Writer side of the video RAM that the VGA renderer reads: accepts one frame of FFT magnitude bins over a valid/ready stream, scales and saturates each bin to a bar height, applies optional peak-hold decay, and writes one height per screen column into the VRAM write port. It sits between the FFT output and the VRAM; the VRAM write clock is tied to this block's clock. The renderer reads each stored height as a signed 10-bit value, so every written height is 0..MAX_HEIGHT with MAX_HEIGHT ≤ 511.

---
 rtl/spectrum_vram_writer_if.sv | 25 ++
 rtl/spectrum_vram_writer.sv | 147 ++++++++++++++
 tb/tb_spectrum_vram_writer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_vram_writer_if.sv
// Bin stream in, VRAM write port and frame-done strobe out, grouped as one bundle.
// The writer takes the slave side; the FFT source / VRAM / testbench take the master side.
interface spectrum_vram_writer_if #(
    parameter int MAG_W = 16
);
    logic             binValid;
    logic             binReady;
    logic [MAG_W-1:0] binData;
    logic             binLast;
    logic             peakHold;
    logic             vramWriteEnable;
    logic [9:0]       vramWriteAddr;
    logic [9:0]       vramInData;
    logic             frameDone;

    modport master (
        output binValid, binData, binLast, peakHold,
        input  binReady, vramWriteEnable, vramWriteAddr, vramInData, frameDone
    );

    modport slave (
        input  binValid, binData, binLast, peakHold,
        output binReady, vramWriteEnable, vramWriteAddr, vramInData, frameDone
    );
endinterface

// File: rtl/spectrum_vram_writer.sv
// Scales FFT bins to bar heights (with optional peak-hold decay) and writes one
// height per screen column into the VRAM, keeping a shadow copy for the decay.
module spectrum_vram_writer #(
    parameter int COLUMNS    = 1024,
    parameter int MAG_W      = 16,
    parameter int SHIFT      = 6,
    parameter int MAX_HEIGHT = 511,
    parameter int DECAY      = 4
) (
    input logic                   inClock,
    input logic                   resetN,
    spectrum_vram_writer_if.slave bus
);
    localparam int         AW    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam logic [10:0] COLS  = 11'(COLUMNS);
    localparam logic [10:0] COLS1 = 11'(COLUMNS + 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_FLUSH, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [10:0]      col_cnt_q, col_cnt_d;
    logic             bin_ready_q, bin_ready_d;
    logic             frame_done_q, frame_done_d;
    logic             s1_valid_q, s1_valid_d;
    logic [9:0]       s1_addr_q, s1_addr_d;
    logic [MAG_W-1:0] s1_mag_q, s1_mag_d;
    logic             s1_peak_q, s1_peak_d;
    logic             wr_en_q, wr_en_d;
    logic [9:0]       wr_addr_q, wr_addr_d;
    logic [9:0]       wr_data_q, wr_data_d;

    logic [9:0]       shadow_mem [COLUMNS];
    logic [9:0]       shadow_rd_q;
    logic             xfer;
    logic [MAG_W-1:0] mag_shift;
    logic [9:0]       height, decayed, out_height;

    assign xfer = bus.binValid & bin_ready_q;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        bin_ready_d  = bin_ready_q;
        frame_done_d = 1'b0;
        s1_valid_d   = 1'b0;
        s1_addr_d    = col_cnt_q[9:0];
        s1_mag_d     = '0;
        s1_peak_d    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                s1_valid_d = (col_cnt_q < COLS);
                col_cnt_d  = col_cnt_q + 11'd1;
                // Two extra counts let the last zero drain before bins are taken.
                if (col_cnt_q == COLS1) begin
                    state_d     = ST_RUN;
                    col_cnt_d   = '0;
                    bin_ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (col_cnt_q < COLS) begin
                        s1_valid_d = 1'b1;
                        s1_mag_d   = bus.binData;
                        s1_peak_d  = bus.peakHold;
                        col_cnt_d  = col_cnt_q + 11'd1;
                    end
                    if (bus.binLast) begin
                        bin_ready_d = 1'b0;
                        state_d     = (col_cnt_q + 11'd1 < COLS) ? ST_FLUSH : ST_DONE;
                    end
                end
            end
            ST_FLUSH: begin
                s1_valid_d = 1'b1;
                s1_peak_d  = bus.peakHold;
                col_cnt_d  = col_cnt_q + 11'd1;
                if (col_cnt_q == COLS - 11'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!s1_valid_q) begin
                    frame_done_d = 1'b1;
                    bin_ready_d  = 1'b1;
                    col_cnt_d    = '0;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        mag_shift  = s1_mag_q >> SHIFT;
        height     = (mag_shift > MAG_W'(MAX_HEIGHT)) ? 10'(MAX_HEIGHT) : mag_shift[9:0];
        decayed    = (shadow_rd_q > 10'(DECAY)) ? shadow_rd_q - 10'(DECAY) : '0;
        out_height = (s1_peak_q && (decayed > height)) ? decayed : height;
        wr_en_d    = s1_valid_q;
        wr_addr_d  = s1_valid_q ? s1_addr_q : wr_addr_q;
        wr_data_d  = s1_valid_q ? out_height : wr_data_q;
    end

    // NOTE: the shadow RAM has no reset; CLEAR rewrites every column after reset,
    // and a resettable memory would not map onto block RAM.
    always_ff @(posedge inClock) begin
        if (s1_valid_q) shadow_mem[s1_addr_q[AW-1:0]] <= out_height;
        shadow_rd_q <= shadow_mem[s1_addr_d[AW-1:0]];
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge inClock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_CLEAR;
            col_cnt_q    <= '0;
            bin_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_mag_q     <= '0;
            s1_peak_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            bin_ready_q  <= bin_ready_d;
            frame_done_q <= frame_done_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_mag_q     <= s1_mag_d;
            s1_peak_q    <= s1_peak_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.binReady        = bin_ready_q;
    assign bus.vramWriteEnable = wr_en_q;
    assign bus.vramWriteAddr   = wr_addr_q;
    assign bus.vramInData      = wr_data_q;
    assign bus.frameDone       = frame_done_q;
endmodule

// File: tb/tb_spectrum_vram_writer.sv
// Directed bench for spectrum_vram_writer with COLUMNS=8: logs every VRAM write
// and frameDone pulse with its cycle number, then checks against hand-computed values.
module tb_spectrum_vram_writer;
    localparam int COLUMNS = 8;
    localparam int MAG_W   = 16;

    logic inClock = 1'b0;
    logic resetN  = 1'b0;

    spectrum_vram_writer_if #(.MAG_W(MAG_W)) bus ();

    spectrum_vram_writer #(
        .COLUMNS(COLUMNS), .MAG_W(MAG_W), .SHIFT(6), .MAX_HEIGHT(511), .DECAY(4)
    ) dut (
        .inClock(inClock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 inClock = ~inClock;

    typedef struct {
        int cyc;
        int addr;
        int data;
        int rdy;
    } wr_t;

    wr_t         wlog [$];
    int          dlog [$];
    int          drdy [$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [15:0] stim [16];
    int          acc  [16];

    always @(posedge inClock) cyc <= cyc + 1;

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge inClock) begin
        wr_t w;
        if (bus.vramWriteEnable === 1'b1) begin
            w.cyc  = cyc;
            w.addr = int'(bus.vramWriteAddr);
            w.data = int'(bus.vramInData);
            w.rdy  = int'(bus.binReady);
            wlog.push_back(w);
        end
        if (bus.frameDone === 1'b1) begin
            dlog.push_back(cyc);
            drdy.push_back(int'(bus.binReady));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        dlog.delete();
        drdy.delete();
    endtask

    task automatic check_wr(input string tag, input int i, input int a, input int d, input int c);
        if (i >= wlog.size()) begin
            check({tag, "_missing"}, wlog.size(), i + 1);
        end else begin
            check({tag, "_addr"}, wlog[i].addr, a);
            check({tag, "_data"}, wlog[i].data, d);
            if (c >= 0) check({tag, "_cyc"}, wlog[i].cyc, c);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_binReady"}, int'(bus.binReady), 0);
        check({tag, "_we"}, int'(bus.vramWriteEnable), 0);
        check({tag, "_addr"}, int'(bus.vramWriteAddr), 0);
        check({tag, "_data"}, int'(bus.vramInData), 0);
        check({tag, "_frameDone"}, int'(bus.frameDone), 0);
    endtask

    // Called with resetN low; releases it and checks the CLEAR sweep.
    task automatic release_and_clear(input string tag);
        int rel;
        clear_logs();
        @(negedge inClock);
        resetN = 1'b1;
        rel    = cyc;
        for (int k = 0; k < 50 && bus.binReady !== 1'b1; k++) @(negedge inClock);
        check({tag, "_ready_cyc"}, cyc - rel, 10);
        check({tag, "_nwr"}, wlog.size(), COLUMNS);
        for (int i = 0; i < COLUMNS; i++)
            check_wr($sformatf("%s_w%0d", tag, i), i, i, 0, rel + 2 + i);
        check({tag, "_ndone"}, dlog.size(), 0);
    endtask

    // Entered and left on a falling edge; acc = cycle in which the transfer happened.
    task automatic send_bin(input logic [15:0] d, input logic last, input logic pk, output int a);
        bus.binValid = 1'b1;
        bus.binData  = d;
        bus.binLast  = last;
        bus.peakHold = pk;
        for (int k = 0; k < 100 && bus.binReady !== 1'b1; k++) @(negedge inClock);
        if (bus.binReady !== 1'b1) check("bin_ready_timeout", int'(bus.binReady), 1);
        a = cyc;
        @(negedge inClock);
    endtask

    task automatic run_frame(input int n, input logic pk, input string tag);
        clear_logs();
        for (int i = 0; i < n; i++) send_bin(stim[i], (i == n - 1), pk, acc[i]);
        bus.binValid = 1'b0;
        bus.binLast  = 1'b0;
        check({tag, "_ready_drop"}, int'(bus.binReady), 0);
        for (int k = 0; k < 100 && dlog.size() == 0; k++) @(negedge inClock);
        repeat (3) @(negedge inClock);
        check({tag, "_ndone"}, dlog.size(), 1);
        if (dlog.size() > 0) check({tag, "_done_rdy"}, drdy[0], 1);
    endtask

    initial begin
        int h2 [8];
        int h3 [8];

        bus.binValid = 1'b0;
        bus.binData  = '0;
        bus.binLast  = 1'b0;
        bus.peakHold = 1'b0;

        // Reset values, then the CLEAR sweep.
        repeat (3) @(negedge inClock);
        check_reset_outputs("t1_rst");
        release_and_clear("t1");

        // Full frame, direct heights, saturation at 511.
        stim[0] = 16'd0;   stim[1] = 16'd64;  stim[2] = 16'd640; stim[3] = 16'd65535;
        stim[4] = 16'd100; stim[5] = 16'd200; stim[6] = 16'd300; stim[7] = 16'd400;
        h2 = '{0, 1, 10, 511, 1, 3, 4, 6};
        run_frame(8, 1'b0, "t2");
        check("t2_nwr", wlog.size(), 8);
        for (int i = 0; i < 8; i++) check_wr($sformatf("t2_w%0d", i), i, i, h2[i], acc[i] + 2);
        if (dlog.size() > 0) check("t2_done_cyc", dlog[0], acc[7] + 3);

        // Early binLast: remaining columns flushed with zero while binReady is low.
        stim[0] = 16'd6400; stim[1] = 16'd128; stim[2] = 16'd64; stim[3] = 16'd640;
        h3 = '{100, 2, 1, 10, 0, 0, 0, 0};
        run_frame(4, 1'b0, "t3");
        check("t3_nwr", wlog.size(), 8);
        for (int i = 0; i < 8; i++) check_wr($sformatf("t3_w%0d", i), i, i, h3[i], acc[0] + 2 + i);
        for (int i = 4; i < 8 && i < wlog.size(); i++)
            check($sformatf("t3_flush_rdy%0d", i), wlog[i].rdy, 0);
        if (dlog.size() > 0) check("t3_done_cyc", dlog[0], acc[0] + 10);

        // Overlong frame: bins beyond column 7 accepted but not written.
        for (int i = 0; i < 12; i++) stim[i] = 16'(i * 64);
        run_frame(12, 1'b0, "t4");
        check("t4_nwr", wlog.size(), 8);
        for (int i = 0; i < 8; i++) check_wr($sformatf("t4_w%0d", i), i, i, i, acc[i] + 2);
        if (dlog.size() > 0) check("t4_done_cyc", dlog[0], acc[11] + 2);

        // Peak hold with DECAY=4.
        stim[0] = 16'd6400; stim[1] = 16'd128;
        run_frame(2, 1'b0, "t5a");
        check_wr("t5a_c0", 0, 0, 100, acc[0] + 2);
        check_wr("t5a_c1", 1, 1, 2, acc[1] + 2);
        stim[0] = 16'd1280; stim[1] = 16'd0;
        run_frame(2, 1'b1, "t5b");
        check_wr("t5b_c0", 0, 0, 96, acc[0] + 2);
        check_wr("t5b_c1", 1, 1, 0, acc[1] + 2);
        stim[0] = 16'd0; stim[1] = 16'd3200;
        run_frame(2, 1'b1, "t5c");
        check_wr("t5c_c0", 0, 0, 92, -1);
        check_wr("t5c_c1", 1, 1, 50, -1);
        stim[0] = 16'd0;
        run_frame(1, 1'b1, "t5d");
        check_wr("t5d_c0", 0, 0, 88, -1);
        check_wr("t5d_c1", 1, 1, 46, -1);
        check_wr("t5d_c2", 2, 2, 0, -1);

        // Reset in the middle of a frame.
        clear_logs();
        stim[0] = 16'd320; stim[1] = 16'd384; stim[2] = 16'd448;
        for (int i = 0; i < 3; i++) send_bin(stim[i], 1'b0, 1'b0, acc[i]);
        bus.binValid = 1'b0;
        #1 resetN = 1'b0;
        #1 check_reset_outputs("t6_rst");
        repeat (2) @(negedge inClock);
        release_and_clear("t6");
        stim[0] = 16'd576;
        run_frame(1, 1'b0, "t6f");
        check("t6f_nwr", wlog.size(), 8);
        check_wr("t6f_c0", 0, 0, 9, acc[0] + 2);
        check_wr("t6f_c7", 7, 7, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
